// File: rtl/div_funct3.sv
// Shared encodings for the radix-2 divider: funct3 operation codes and data width.
// The operation code only chooses signed vs unsigned arithmetic; Q and R are always both produced.
package div_funct3;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    DIV  = 3'b100,
    DIVU = 3'b101,
    REM  = 3'b110,
    REMU = 3'b111
  } div_funct3_t;

  function automatic logic is_signed_op(input div_funct3_t op);
    return (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/radix2_divider_if.sv
// Request/result bundle between a pipeline and the divider.
// The pipeline holds while div_stall is high and takes the result on the o_rdy pulse.
interface radix2_divider_if;
  import div_funct3::*;

  logic              start;
  div_funct3_t       div_op;
  logic [XLEN-1:0]   A;
  logic [XLEN-1:0]   B;
  logic [XLEN-1:0]   Q;
  logic [XLEN-1:0]   R;
  logic              o_rdy;
  logic              div_stall;

  modport master (
    output start, div_op, A, B,
    input  Q, R, o_rdy, div_stall
  );

  modport slave (
    input  start, div_op, A, B,
    output Q, R, o_rdy, div_stall
  );

endinterface

// File: rtl/div_controller.sv
// Divider sequencing FSM (IDLE/SETUP/ITER/FIX/DONE): 32-step iteration counter, o_rdy and div_stall.
// Normal path reaches DONE 35 cycles after acceptance, fast path 2; start is only honoured in IDLE/DONE.
module div_controller (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic fast_path,
  output logic accept,
  output logic in_setup,
  output logic in_iter,
  output logic in_fix,
  output logic o_rdy,
  output logic div_stall
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        o_rdy_q, o_rdy_d;
  logic        idle_or_done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idle_or_done = (state_q == IDLE) || (state_q == DONE);

    case (state_q)
      IDLE, DONE: state_d = start ? SETUP : IDLE;
      SETUP: begin
        if (fast_path) begin
          state_d = DONE;
        end else begin
          state_d = ITER;
          cnt_d   = 5'd0;
        end
      end
      ITER: begin
        // 5-bit counter wraps 31->0 on the same edge that leaves for FIX
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase

    o_rdy_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      o_rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_rdy_q <= o_rdy_d;
    end
  end

  assign accept    = idle_or_done && start;
  assign in_setup  = (state_q == SETUP);
  assign in_iter   = (state_q == ITER);
  assign in_fix    = (state_q == FIX);
  assign o_rdy     = o_rdy_q;
  assign div_stall = accept || in_setup || in_iter || in_fix;

endmodule

// File: rtl/radix2_divider.sv
// 32-bit restoring radix-2 divider producing quotient and remainder together (RISC-V M semantics).
// 35-cycle latency (2 for divide-by-zero / signed overflow); div_stall holds the issuing pipeline meanwhile.
module radix2_divider
  import div_funct3::*;
(
  input  logic                clk,
  input  logic                rst,
  radix2_divider_if.slave     bus
);

  logic              accept, in_setup, in_iter, in_fix;
  logic              ctl_o_rdy, ctl_div_stall;
  logic              fast_path, div_zero, sgn_ovf;

  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dsr_q, dsr_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [XLEN-1:0]   q_out_q, q_out_d;
  logic [XLEN-1:0]   r_out_q, r_out_d;

  logic [XLEN:0]     rem_shift;
  logic [XLEN+1:0]   diff;

  div_controller u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (bus.start),
    .fast_path (fast_path),
    .accept    (accept),
    .in_setup  (in_setup),
    .in_iter   (in_iter),
    .in_fix    (in_fix),
    .o_rdy     (ctl_o_rdy),
    .div_stall (ctl_div_stall)
  );

  assign div_zero  = (b_q == '0);
  assign sgn_ovf   = sgn_q && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign fast_path = div_zero || sgn_ovf;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;

    // Dividend bits are shifted out of dvd_q while quotient bits shift in behind them
    rem_shift = {rem_q[XLEN-1:0], dvd_q[XLEN-1]};
    diff      = {1'b0, rem_shift} - {2'b00, dsr_q};

    if (accept) begin
      a_d   = bus.A;
      b_d   = bus.B;
      sgn_d = is_signed_op(bus.div_op);
    end

    if (in_setup) begin
      dvd_d   = (sgn_q && a_q[XLEN-1]) ? (~a_q + 32'd1) : a_q;
      dsr_d   = (sgn_q && b_q[XLEN-1]) ? (~b_q + 32'd1) : b_q;
      q_neg_d = sgn_q && (a_q[XLEN-1] ^ b_q[XLEN-1]);
      r_neg_d = sgn_q && a_q[XLEN-1];
      rem_d   = '0;
      if (div_zero) begin
        q_out_d = 32'hFFFF_FFFF;
        r_out_d = a_q;
      end else if (sgn_ovf) begin
        q_out_d = 32'h8000_0000;
        r_out_d = 32'h0000_0000;
      end
    end

    if (in_iter) begin
      if (!diff[XLEN+1]) begin
        rem_d = diff[XLEN:0];
        dvd_d = {dvd_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = rem_shift;
        dvd_d = {dvd_q[XLEN-2:0], 1'b0};
      end
    end

    if (in_fix) begin
      q_out_d = q_neg_q ? (~dvd_q + 32'd1) : dvd_q;
      r_out_d = r_neg_q ? (~rem_q[XLEN-1:0] + 32'd1) : rem_q[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
    end
  end

  assign bus.Q         = q_out_q;
  assign bus.R         = r_out_q;
  assign bus.o_rdy     = ctl_o_rdy;
  assign bus.div_stall = ctl_div_stall;

endmodule

// File: tb/tb_radix2_divider.sv
// Bench for radix2_divider: vector table, directed multi-cycle sequences and random ops vs an arithmetic model.
module tb_radix2_divider;
  import div_funct3::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  radix2_divider_if bus ();

  radix2_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int fails  = 0;

  typedef struct {
    div_funct3_t op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension division rules in plain arithmetic
  function automatic void ref_div(input div_funct3_t op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
    logic signed [31:0] sa, sb, sq, sr;
    sa  = a;
    sb  = b;
    lat = 35;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 2;
    end else if (op == DIV || op == REM) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0; lat = 2;
      end else begin
        sq = sa / sb; sr = sa % sb;
        q = sq; r = sr;
      end
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Cycle k = k-th cycle after the one in which start was accepted
  task automatic do_op(input div_funct3_t op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output int lat, output bit stall_ok);
    stall_ok = 1'b1;
    lat      = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.div_op = op; bus.A = a; bus.B = b;
    #1 if (!bus.div_stall) stall_ok = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (bus.o_rdy) begin
        lat = k;
        if (bus.div_stall) stall_ok = 1'b0;
        break;
      end
      if (!bus.div_stall) stall_ok = 1'b0;
    end
    q = bus.Q;
    r = bus.R;
  endtask

  initial begin
    logic [31:0] q, r, eq, er;
    int          lat, elat, pulses, first_k;
    bit          stall_ok;
    int          rdy_k[$];
    logic [31:0] rdy_q[$], rdy_r[$];
    div_funct3_t op;
    logic [31:0] a, b;

    tbl[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         32'd2,          35};
    tbl[1]  = '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  35};
    tbl[2]  = '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  35};
    tbl[3]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          2};
    tbl[4]  = '{DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          2};
    tbl[5]  = '{DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          35};
    tbl[6]  = '{REMU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          35};
    tbl[7]  = '{DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  2};
    tbl[8]  = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  35};
    tbl[9]  = '{DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          35};
    tbl[10] = '{REMU, 32'd9,          32'd3,          32'd3,          32'd0,          35};

    rst = 1'b1;
    bus.start = 1'b0; bus.div_op = DIVU; bus.A = '0; bus.B = '0;
    #12;
    chk("reset Q", bus.Q, 32'd0);
    chk("reset R", bus.R, 32'd0);
    chk("reset o_rdy", {31'd0, bus.o_rdy}, 32'd0);
    chk("reset div_stall", {31'd0, bus.div_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, q, r, lat, stall_ok);
      chk($sformatf("vec%0d Q", i), q, tbl[i].q);
      chk($sformatf("vec%0d R", i), r, tbl[i].r);
      chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d div_stall", i), {31'd0, stall_ok}, 32'd1);
    end

    // Back-to-back: start held high, operands switched after the first acceptance
    @(negedge clk);
    bus.start = 1'b1; bus.div_op = DIVU; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk);
    #1 bus.A = 32'd9; bus.B = 32'd3;
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 36) bus.start = 1'b0;
      if (k == 35) chk("b2b stall in DONE", {31'd0, bus.div_stall}, 32'd1);
      if (bus.o_rdy) begin
        rdy_k.push_back(k); rdy_q.push_back(bus.Q); rdy_r.push_back(bus.R);
      end
    end
    chk("b2b pulse count", rdy_k.size(), 32'd2);
    if (rdy_k.size() >= 2) begin
      chk("b2b first cycle", rdy_k[0], 32'd35);
      chk("b2b first Q", rdy_q[0], 32'd14);
      chk("b2b first R", rdy_r[0], 32'd2);
      chk("b2b second cycle", rdy_k[1], 32'd70);
      chk("b2b second Q", rdy_q[1], 32'd3);
      chk("b2b second R", rdy_r[1], 32'd0);
    end

    // Asynchronous reset in the middle of an iteration
    @(negedge clk);
    bus.start = 1'b1; bus.div_op = DIVU; bus.A = 32'd1000; bus.B = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst Q", bus.Q, 32'd0);
    chk("midrst R", bus.R, 32'd0);
    chk("midrst o_rdy", {31'd0, bus.o_rdy}, 32'd0);
    chk("midrst div_stall", {31'd0, bus.div_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (bus.o_rdy) pulses++;
    end
    chk("midrst no o_rdy", pulses, 32'd0);
    do_op(DIVU, 32'd20, 32'd6, q, r, lat, stall_ok);
    chk("post-rst Q", q, 32'd3);
    chk("post-rst R", r, 32'd2);
    chk("post-rst latency", lat, 32'd35);

    // start pulsed during ITER with other operands must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.div_op = DIVU; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    pulses = 0; first_k = -1; q = '0; r = '0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 5) begin bus.start = 1'b1; bus.div_op = DIV; bus.A = 32'd55; bus.B = 32'd5; end
      if (k == 6) bus.start = 1'b0;
      if (bus.o_rdy) begin
        pulses++;
        if (first_k < 0) begin first_k = k; q = bus.Q; r = bus.R; end
      end
    end
    chk("iter-start pulses", pulses, 32'd1);
    chk("iter-start cycle", first_k, 32'd35);
    chk("iter-start Q", q, 32'd14);
    chk("iter-start R", r, 32'd2);

    // Random operations against the arithmetic model
    for (int n = 0; n < 150; n++) begin
      op = div_funct3_t'(3'b100 | 3'($urandom_range(0, 3)));
      a  = (($urandom_range(0, 9)) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      ref_div(op, a, b, eq, er, elat);
      do_op(op, a, b, q, r, lat, stall_ok);
      chk($sformatf("rand%0d op=%0b a=%h b=%h Q", n, op, a, b), q, eq);
      chk($sformatf("rand%0d op=%0b a=%h b=%h R", n, op, a, b), r, er);
      chk($sformatf("rand%0d latency", n), lat, elat);
    end

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule

// File: doc/radix2_divider.md
RADIX2_DIVIDER -- requirements
Module: radix2_divider

Interface
REQ-001 SHALL have no parameters; data width fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 div_op  input  div_funct3_t (3)  DIV=3'b100, DIVU=3'b101, REM=3'b110, REMU=3'b111.
REQ-006 A  input  32  dividend (rs1).
REQ-007 B  input  32  divisor (rs2).
REQ-008 Q  output  32  quotient, registered.
REQ-009 R  output  32  remainder, registered.
REQ-010 o_rdy  output  1  result-valid pulse.
REQ-011 div_stall  output  1  pipeline hold request.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ITER, FIX, DONE.
REQ-013 IDLE/DONE: start=1 -> SETUP and latch A, B, div_op; start=0 -> IDLE.
REQ-014 SETUP SHALL take the magnitude of each operand (signed ops only, MSB=1 -> two's complement) and record quotient and remainder sign flags.
REQ-015 SETUP -> DONE directly when B==0 or (signed op, A==32'h8000_0000, B==32'hFFFF_FFFF); otherwise -> ITER with 5-bit counter cleared.
REQ-016 ITER SHALL perform one restoring shift-subtract step per cycle (33-bit partial remainder), for exactly 32 cycles; counter wraps 31->0 on the exit edge into FIX.
REQ-017 FIX SHALL negate quotient if operand signs differ (signed only), negate remainder if dividend negative (signed only), then -> DONE.
REQ-018 Divide-by-zero: Q=32'hFFFF_FFFF, R=A, for all four ops.
REQ-019 Signed overflow: Q=32'h8000_0000, R=0.
REQ-020 Q and R SHALL hold both results regardless of div_op; div_op only selects signedness; consumer selects Q (DIV/DIVU) or R (REM/REMU).
REQ-021 o_rdy SHALL be 1 exactly during the DONE cycle, 0 otherwise.
REQ-022 Q/R SHALL be valid in DONE and hold until the next FIX or fast-path DONE overwrite.
REQ-023 div_stall SHALL be 1 combinationally in IDLE/DONE when start=1, 1 in SETUP, ITER, FIX, 0 otherwise.
REQ-024 Latency, normal path: start accepted cycle 0 -> o_rdy cycle 35; fast path: o_rdy cycle 2.
REQ-025 start asserted in SETUP/ITER/FIX SHALL be ignored; operands SHALL not change mid-operation.
REQ-026 start in DONE SHALL be accepted (back-to-back); o_rdy still pulses that cycle for the prior result.

Reset
REQ-027 rst SHALL force IDLE, counter=0, Q=0, R=0, o_rdy=0, div_stall=0 (start=0), immediately and asynchronously.
REQ-028 rst mid-operation SHALL abandon the operation with no o_rdy pulse; next start after release SHALL compute normally.

Structure
REQ-029 Package div_funct3 SHALL define div_funct3_t (the four encodings); FSM state enum SHALL be local to the module.
REQ-030 One sub-module, div_controller, SHALL hold the FSM, iteration counter, o_rdy and div_stall; the datapath SHALL stay in radix2_divider.

Verification
REQ-031 DIVU A=100, B=7 -> o_rdy at cycle 35, Q=14, R=2; div_stall 1 in cycles 0-34.
REQ-032 DIV A=-7 (32'hFFFF_FFF9), B=2 -> Q=-3 (32'hFFFF_FFFD), R=-1 (32'hFFFF_FFFF); REM same operands -> same Q/R.
REQ-033 DIV A=32'h8000_0000, B=32'hFFFF_FFFF -> o_rdy at cycle 2, Q=32'h8000_0000, R=0; DIVU B=0, A=5 -> cycle 2, Q=32'hFFFF_FFFF, R=5.
REQ-034 Back-to-back: start held high from cycle 0, second op A=9, B=3 DIVU -> first o_rdy cycle 35, second o_rdy cycle 70, Q=3, R=0.
REQ-035 rst pulsed at cycle 10 of an operation -> outputs zero immediately, no o_rdy; subsequent DIVU 20/6 -> Q=3, R=2.
REQ-036 start toggled during ITER with different A/B -> result unaffected, single o_rdy pulse.
